// File: rtl/alu_fu_broadcast_pkg.sv
// Shared ALU definitions: datapath widths and the function encoding used by the
// reservation station and the ALU functional unit.
package alu_fu_broadcast_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROB_TAG_LEN = 5;
    localparam int unsigned SHAMT_LEN   = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_func_t;

endpackage

// File: rtl/alu_fu_broadcast_if.sv
// Issue and result-broadcast signals between the reservation station / CDB
// arbiter (master) and the ALU functional unit (slave).
interface alu_fu_broadcast_if;
    import alu_fu_broadcast_pkg::*;

    logic                   start;
    alu_func_t              func;
    logic [XLEN-1:0]        v1;
    logic [XLEN-1:0]        v2;
    logic [ROB_TAG_LEN-1:0] dst_tag;
    logic                   fu_ready;
    logic                   cdb_req;
    logic                   cdb_grant;
    logic                   wakeup;
    logic [ROB_TAG_LEN-1:0] wakeup_tag;
    logic [XLEN-1:0]        wakeup_value;
    logic                   overflow_err;

    modport master (
        output start, func, v1, v2, dst_tag, cdb_grant,
        input  fu_ready, cdb_req, wakeup, wakeup_tag, wakeup_value, overflow_err
    );

    modport slave (
        input  start, func, v1, v2, dst_tag, cdb_grant,
        output fu_ready, cdb_req, wakeup, wakeup_tag, wakeup_value, overflow_err
    );

endinterface

// File: rtl/alu_fu_broadcast_alu_comb.sv
// Purely combinational integer ALU; undefined function codes produce zero.
module alu_comb
    import alu_fu_broadcast_pkg::*;
(
    input  alu_func_t       func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHAMT_LEN-1:0] shamt;

    assign shamt = b[SHAMT_LEN-1:0];

    always_comb begin
        result = '0;
        case (func)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_fu_broadcast.sv
// ALU functional unit: fixed-latency pipeline feeding a credit-protected result
// queue whose head is broadcast on the common data bus when granted.
module alu_fu_broadcast
    import alu_fu_broadcast_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_fu_broadcast_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = $clog2(QDEPTH + LATENCY + 1);

    logic                   accept;
    logic                   s1_valid;
    alu_func_t              s1_func;
    logic [XLEN-1:0]        s1_a;
    logic [XLEN-1:0]        s1_b;
    logic [ROB_TAG_LEN-1:0] s1_tag;
    logic [XLEN-1:0]        alu_result;

    logic                   push;
    logic [XLEN-1:0]        push_value;
    logic [ROB_TAG_LEN-1:0] push_tag;
    logic [OCC_W-1:0]       in_flight;

    logic [XLEN-1:0]        q_value [QDEPTH];
    logic [ROB_TAG_LEN-1:0] q_tag   [QDEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   pop;

    // Credit counts every result already committed to a queue slot, so a push never finds the queue full.
    assign bus.fu_ready = (OCC_W'(count) + in_flight) < OCC_W'(QDEPTH);
    assign accept       = bus.start && bus.fu_ready;
    assign bus.cdb_req  = (count != '0);
    assign pop          = bus.cdb_req && bus.cdb_grant;

    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= accept;
        if (accept) begin
            s1_func <= bus.func;
            s1_a    <= bus.v1;
            s1_b    <= bus.v2;
            s1_tag  <= bus.dst_tag;
        end
    end

    alu_comb u_alu (
        .func   (s1_func),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result)
    );

    if (LATENCY == 1) begin : g_direct
        assign push       = s1_valid;
        assign push_value = alu_result;
        assign push_tag   = s1_tag;
        assign in_flight  = OCC_W'(s1_valid);
    end else begin : g_stages
        // Result registers for stages 2..LATENCY; the last one feeds the queue.
        logic [LATENCY-2:0]     r_valid;
        logic [XLEN-1:0]        r_value [LATENCY-1];
        logic [ROB_TAG_LEN-1:0] r_tag   [LATENCY-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= s1_valid;
                for (int unsigned k = 1; k < LATENCY - 1; k++) r_valid[k] <= r_valid[k-1];
            end
            r_value[0] <= alu_result;
            r_tag[0]   <= s1_tag;
            for (int unsigned k = 1; k < LATENCY - 1; k++) begin
                r_value[k] <= r_value[k-1];
                r_tag[k]   <= r_tag[k-1];
            end
        end

        always_comb begin
            in_flight = OCC_W'(s1_valid);
            for (int unsigned k = 0; k < LATENCY - 1; k++) in_flight = in_flight + OCC_W'(r_valid[k]);
        end

        assign push       = r_valid[LATENCY-2];
        assign push_value = r_value[LATENCY-2];
        assign push_tag   = r_tag[LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_value[wr_ptr] <= push_value;
            q_tag[wr_ptr]   <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wakeup       <= 1'b0;
            bus.wakeup_tag   <= '0;
            bus.wakeup_value <= '0;
            bus.overflow_err <= 1'b0;
        end else begin
            bus.wakeup <= pop;
            if (pop) begin
                bus.wakeup_tag   <= q_tag[rd_ptr];
                bus.wakeup_value <= q_value[rd_ptr];
            end
            if (bus.start && !bus.fu_ready) bus.overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_fu_broadcast.sv
// Directed bench for alu_fu_broadcast: a transaction-level model (list of issued
// results with the cycle each becomes broadcastable) is compared every cycle.
module tb_alu_fu_broadcast;
    import alu_fu_broadcast_pkg::*;

    localparam int unsigned LATENCY = 2;
    localparam int unsigned QDEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_fu_broadcast_if bus();

    alu_fu_broadcast #(.LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
        int                     ready;
    } op_t;

    typedef struct {
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
        int                     cyc;
    } bc_t;

    op_t pend[$];
    bc_t log_q[$];
    int  cyc = 0;
    bit  model_on = 1'b0;
    bit  room, head_ready;
    op_t new_op;
    bc_t new_bc;
    logic                   exp_wakeup, exp_ovf;
    logic [ROB_TAG_LEN-1:0] exp_tag;
    logic [XLEN-1:0]        exp_value;

    function automatic logic [31:0] ref_alu(input alu_func_t f, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh   = b % 32;
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | fill;
            ALU_SLT:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // An op accepted at edge e is queued at edge e+LATENCY and poppable from edge e+LATENCY+1.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            pend.delete();
            exp_wakeup = 1'b0;
            exp_tag    = '0;
            exp_value  = '0;
            exp_ovf    = 1'b0;
            model_on   = 1'b1;
        end else if (model_on) begin
            room       = pend.size() < QDEPTH;
            head_ready = pend.size() > 0 && pend[0].ready <= cyc;
            if (head_ready && bus.cdb_grant === 1'b1) begin
                exp_wakeup = 1'b1;
                exp_tag    = pend[0].tag;
                exp_value  = pend[0].value;
                void'(pend.pop_front());
            end else begin
                exp_wakeup = 1'b0;
            end
            if (bus.start === 1'b1) begin
                if (room) begin
                    new_op.tag   = bus.dst_tag;
                    new_op.value = ref_alu(bus.func, bus.v1, bus.v2);
                    new_op.ready = cyc + LATENCY + 1;
                    pend.push_back(new_op);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("fu_ready",     32'(bus.fu_ready),     32'(pend.size() < QDEPTH));
            check("cdb_req",      32'(bus.cdb_req),      32'(pend.size() > 0 && pend[0].ready <= cyc));
            check("wakeup",       32'(bus.wakeup),       32'(exp_wakeup));
            check("wakeup_tag",   32'(bus.wakeup_tag),   32'(exp_tag));
            check("wakeup_value", bus.wakeup_value,      exp_value);
            check("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
            if (bus.wakeup === 1'b1) begin
                new_bc.tag   = bus.wakeup_tag;
                new_bc.value = bus.wakeup_value;
                new_bc.cyc   = cyc;
                log_q.push_back(new_bc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input alu_func_t f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.start   = 1'b1;
        bus.func    = f;
        bus.v1      = a;
        bus.v2      = b;
        bus.dst_tag = tag;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic issue(input alu_func_t f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        while (bus.fu_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) fail_now("issue_wait");
        drive(f, a, b, tag);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (pend.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (pend.size() != 0) fail_now("idle_wait");
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    alu_func_t   s2_func [12] = '{ALU_SUB, ALU_SRA, ALU_SLT, ALU_SLTU, alu_func_t'(4'd12), ALU_AND,
                                  ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD};
    logic [31:0] s2_a    [12] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 32'hF0F0_F0F0,
                                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1, 32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] s2_b    [12] = '{32'h1, 32'h4, 32'h1, 32'h1, 32'h4, 32'hFF00_FF00,
                                  32'hFF00_FF00, 32'hFF00_FF00, 32'h25, 32'd31, 32'd30, 32'h2};
    logic [31:0] s2_exp  [12] = '{32'hFFFF_FFFF, 32'hF800_0000, 32'h1, 32'h0, 32'h0, 32'hF000_F000,
                                  32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h20, 32'h1, 32'h1, 32'h1};

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.func      = ALU_ADD;
        bus.v1        = '0;
        bus.v2        = '0;
        bus.dst_tag   = '0;
        bus.cdb_grant = 1'b0;
        tick();
        tick();
        check("rst_fu_ready", 32'(bus.fu_ready), 32'd1);
        check("rst_cdb_req",  32'(bus.cdb_req),  32'd0);
        check("rst_wakeup",   32'(bus.wakeup),   32'd0);
        check("rst_tag",      32'(bus.wakeup_tag), 32'd0);
        check("rst_value",    bus.wakeup_value,  32'd0);
        check("rst_ovf",      32'(bus.overflow_err), 32'd0);
        reset = 1'b0;

        // Single op, grant tied high.
        bus.cdb_grant = 1'b1;
        drive(ALU_ADD, 32'd5, 32'd7, 5'd3);
        check("s1_req_c1", 32'(bus.cdb_req), 32'd0);
        tick();
        check("s1_req_c2", 32'(bus.cdb_req), 32'd0);
        tick();
        check("s1_req_c3", 32'(bus.cdb_req), 32'd1);
        check("s1_wk_c3",  32'(bus.wakeup),  32'd0);
        tick();
        check("s1_wk",    32'(bus.wakeup), 32'd1);
        check("s1_tag",   32'(bus.wakeup_tag), 32'd3);
        check("s1_value", bus.wakeup_value, 32'd12);
        tick();
        check("s1_wk_off",  32'(bus.wakeup), 32'd0);
        check("s1_tag_hold", 32'(bus.wakeup_tag), 32'd3);

        // All functions back to back, including signed cases and an undefined code.
        log_q.delete();
        for (int i = 0; i < 12; i++) issue(s2_func[i], s2_a[i], s2_b[i], 5'(i + 5));
        wait_idle(100);
        check("s2_count", 32'(log_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            check($sformatf("s2_tag%0d", i),   32'(log_q[i].tag), 32'(i + 5));
            check($sformatf("s2_value%0d", i), log_q[i].value,    s2_exp[i]);
        end

        // Spurious grant on an empty queue.
        log_q.delete();
        repeat (3) tick();
        check("sp_wakeup", 32'(bus.wakeup), 32'd0);
        check("sp_req",    32'(bus.cdb_req), 32'd0);
        check("sp_tag",    32'(bus.wakeup_tag), 32'd16);
        check("sp_value",  bus.wakeup_value, 32'd1);
        check("sp_count",  32'(log_q.size()), 32'd0);

        // Backpressure: five starts with no grant, the fifth is illegal.
        do_reset();
        log_q.delete();
        bus.cdb_grant = 1'b0;
        for (int t = 1; t <= 5; t++) drive(ALU_ADD, 32'(t * 16), 32'(t), 5'(t));
        check("bp_ready", 32'(bus.fu_ready), 32'd0);
        check("bp_ovf",   32'(bus.overflow_err), 32'd1);
        repeat (3) tick();
        check("bp_req",   32'(bus.cdb_req), 32'd1);
        bus.cdb_grant = 1'b1;
        wait_idle(50);
        check("bp_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check($sformatf("bp_tag%0d", i),   32'(log_q[i].tag), 32'(i + 1));
            check($sformatf("bp_value%0d", i), log_q[i].value,    32'((i + 1) * 17));
            check($sformatf("bp_cyc%0d", i),   32'(log_q[i].cyc - log_q[0].cyc), 32'(i));
        end
        check("bp_ovf_sticky", 32'(bus.overflow_err), 32'd1);

        // Full queue, then drain while refilling.
        do_reset();
        check("ovf_cleared", 32'(bus.overflow_err), 32'd0);
        log_q.delete();
        bus.cdb_grant = 1'b0;
        for (int t = 1; t <= 4; t++) issue(ALU_XOR, 32'(t), 32'h100, 5'(t));
        repeat (3) tick();
        check("full_ready", 32'(bus.fu_ready), 32'd0);
        check("full_req",   32'(bus.cdb_req), 32'd1);
        bus.cdb_grant = 1'b1;
        for (int t = 5; t <= 8; t++) issue(ALU_XOR, 32'(t), 32'h100, 5'(t));
        wait_idle(60);
        check("full_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check($sformatf("full_tag%0d", i),   32'(log_q[i].tag), 32'(i + 1));
            check($sformatf("full_value%0d", i), log_q[i].value,    32'h100 | 32'(i + 1));
        end

        // Reset with two results queued and two in the pipeline; a start during reset is ignored.
        log_q.delete();
        bus.cdb_grant = 1'b0;
        for (int t = 9; t <= 12; t++) drive(ALU_ADD, 32'(t), 32'd1, 5'(t));
        check("mf_req_before", 32'(bus.cdb_req), 32'd1);
        reset         = 1'b1;
        bus.cdb_grant = 1'b1;
        bus.start     = 1'b1;
        bus.dst_tag   = 5'd13;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("mf_ready",  32'(bus.fu_ready), 32'd1);
        check("mf_req",    32'(bus.cdb_req),  32'd0);
        check("mf_wakeup", 32'(bus.wakeup),   32'd0);
        repeat (10) tick();
        check("mf_none",   32'(log_q.size()), 32'd0);
        check("mf_ready2", 32'(bus.fu_ready), 32'd1);
        check("mf_req2",   32'(bus.cdb_req),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_fu_broadcast.md
ALU_FU_BROADCAST -- requirements
Module: alu_fu_broadcast

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2: ALU pipeline stages from accept to result-queue entry; legal range 1..4.
REQ-002 The block SHALL have parameter QDEPTH, default 4: result-queue entries; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: operation valid from the reservation station this cycle.
REQ-006 The block SHALL have port func, input, ALU_FUNC: operation select.
REQ-007 The block SHALL have ports v1 and v2, input, XLEN bits each: source operand values.
REQ-008 The block SHALL have port dst_tag, input, ROB_TAG_LEN bits: destination tag of the operation.
REQ-009 The block SHALL have port fu_ready, output, 1 bit: the block can accept start this cycle.
REQ-010 The block SHALL have port cdb_req, output, 1 bit: the result queue is non-empty and requests the broadcast bus.
REQ-011 The block SHALL have port cdb_grant, input, 1 bit: bus granted this cycle.
REQ-012 The block SHALL have port wakeup, output, 1 bit: a broadcast is valid this cycle.
REQ-013 The block SHALL have ports wakeup_tag (ROB_TAG_LEN bits) and wakeup_value (XLEN bits), output: the broadcast result.
REQ-014 The block SHALL have port overflow_err, output, 1 bit: sticky flag set when start arrives while fu_ready is 0.

Function
REQ-015 Accept: when start is 1 and fu_ready is 1 at a rising edge, {func, v1, v2, dst_tag} SHALL enter pipeline stage 1.
REQ-016 Pipeline: the result SHALL be computed from the stage-1 operands and SHALL push into the result queue LATENCY edges after acceptance. Stages SHALL advance every cycle with no stalls.
REQ-017 Arithmetic: ADD/SUB SHALL wrap modulo 2^XLEN; AND/OR/XOR SHALL be bitwise.
REQ-018 Shifts: SLL/SRL/SRA SHALL use v2[log2(XLEN)-1:0] as the shift amount; SRA SHALL sign-fill.
REQ-019 Compares: SLT (signed) and SLTU (unsigned) SHALL return 1 or 0, zero-extended.
REQ-020 An undefined func SHALL yield result 0.
REQ-021 Credit: fu_ready SHALL be combinational and equal 1 iff (queue count + valid pipeline stages) < QDEPTH, so the queue can never overflow.
REQ-022 An illegal start (start=1, fu_ready=0) SHALL be dropped and SHALL set overflow_err until reset.
REQ-023 Queue: the queue SHALL be a FIFO with wrapping read and write pointers. cdb_req SHALL be combinational and equal 1 iff count > 0.
REQ-024 Pop: when cdb_req and cdb_grant are both 1 at an edge, the head SHALL pop. For the next cycle only, wakeup SHALL be 1 and wakeup_tag/wakeup_value SHALL hold the popped entry (registered outputs).
REQ-025 When no pop occurs, wakeup SHALL be 0 and wakeup_tag/wakeup_value SHALL hold their last values.
REQ-026 A cdb_grant while cdb_req is 0 SHALL be ignored.
REQ-027 Simultaneous push and pop in one cycle SHALL both occur with count unchanged, including at count = QDEPTH and count = 0 with bypass forbidden: an entry pushed into an empty queue is poppable no earlier than the next cycle.
REQ-028 Back-to-back accepts every cycle SHALL be legal while fu_ready stays 1.
REQ-029 Ordering: results SHALL be broadcast in acceptance order.

Reset
REQ-030 While reset is 1 at an edge, the block SHALL clear all pipeline valid bits, queue pointers and count, and overflow_err. Outputs SHALL read wakeup=0, wakeup_tag=0, wakeup_value=0, cdb_req=0, fu_ready=1 on the following cycle.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight and queued results with no broadcast; start in the same cycle as reset SHALL be ignored.

Structure
REQ-032 ALU_FUNC (enum), XLEN and ROB_TAG_LEN SHALL come from the shared package/header also used by the reservation station; no local redefinition.
REQ-033 The combinational ALU SHALL be a separate sub-module, alu_comb (inputs func, a, b; output result). Queue and pipeline SHALL stay in alu_fu_broadcast.

Verification
REQ-034 Scenario, single op: reset, then start ADD v1=5 v2=7 tag=3, cdb_grant tied 1 -> cdb_req rises 2 cycles after accept; wakeup=1 tag=3 value=12 exactly one cycle later.
REQ-035 Scenario, signed ops: SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000>>4 -> 0xF8000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
REQ-036 Scenario, backpressure: grant held 0, start every cycle -> exactly 4 accepted (tags 1..4), fu_ready=0 afterwards; one extra start -> overflow_err=1. Then grant 1 -> tags 1,2,3,4 broadcast in order on consecutive cycles.
REQ-037 Scenario, full queue push/pop: queue full, grant 1 and start the same cycle -> count stays 4, no loss, order preserved.
REQ-038 Scenario, reset mid-flight: 2 ops in the pipeline and 2 queued, assert reset one cycle -> no wakeup ever for those tags, fu_ready=1, cdb_req=0.
REQ-039 Scenario, spurious grant: cdb_grant=1 with an empty queue -> wakeup stays 0 and outputs unchanged.
